syn_input_arbiter: RTL and testbench

Shares the neuron's single 8-bit synaptic-current input (I_syn) among NREQ event sources. Requesters raise req with a weight. A round-robin arbiter grants one requester per cycle, and the granted weights are summed with saturation over a fixed window of TSTEP cycles. At the end of each window the sum is presented to the neuron datapath as a one-cycle-valid I_syn sample, and the accumulator clears. The block sits between the spike/stimulus sources and the neuron in the top-level wrapper.

---
 rtl/syn_input_arbiter_if.sv | 33 +++
 rtl/syn_input_arbiter.sv | 149 ++++++++++++++
 tb/tb_syn_input_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/syn_input_arbiter_if.sv
// Request/grant and synaptic-current bus between event sources, the arbiter
// and the neuron datapath.
interface syn_input_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] weight;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      i_syn;
    logic              i_syn_valid;
    logic              sat;

    // Event sources and the neuron side.
    modport master (
        output req,
        output weight,
        input  ack,
        input  i_syn,
        input  i_syn_valid,
        input  sat
    );

    // The arbiter itself.
    modport slave (
        input  req,
        input  weight,
        output ack,
        output i_syn,
        output i_syn_valid,
        output sat
    );
endinterface

// File: rtl/syn_input_arbiter.sv
// Round-robin arbiter that shares the neuron's single I_syn input among NREQ
// event sources. Granted weights are summed with saturation over a window
// of TSTEP enabled cycles, then presented as a one-cycle-valid sample.
module syn_input_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int TSTEP = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    syn_input_arbiter_if.slave      bus,
    output logic [7:0]              win_cnt
);

    localparam int           PW       = $clog2(NREQ);
    localparam logic [7:0]   WIN_LAST = 8'(TSTEP - 1);
    localparam logic [W-1:0] SAT_MAX  = '1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] rr_next;
    logic          granted;
    logic [NREQ-1:0] ack_c;
    logic [W-1:0]  gnt_weight;
    logic [W:0]    sum_raw;
    logic          clip;
    logic [W-1:0]  sum_clip;

    logic [W-1:0]  acc;
    logic          sat_pend;
    logic [W-1:0]  i_syn_q;
    logic          sat_q;
    logic          valid_q;

    // Window timer runs down; the window closes on its terminal count.
    logic [7:0]    win_rem;
    logic          win_end;

    // Requester index 'off' positions past 'base', wrapping at NREQ so that
    // non-power-of-two requester counts rotate correctly.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= NREQ) begin
            j = j - NREQ;
        end
        return PW'(j);
    endfunction

    // Priority scan starting at the round-robin pointer; first request wins.
    // Reset is folded in so ack drops the instant rst_n asserts.
    always_comb begin
        granted = 1'b0;
        gnt_idx = '0;
        if (en && rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!granted && bus.req[rr_index(rr_ptr, i)]) begin
                    granted = 1'b1;
                    gnt_idx = rr_index(rr_ptr, i);
                end
            end
        end
    end

    // One-hot grant and the pointer value that follows the winner.
    always_comb begin
        ack_c = '0;
        if (granted) begin
            ack_c[gnt_idx] = 1'b1;
        end
        if (gnt_idx == PW'(NREQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = gnt_idx + PW'(1);
        end
    end

    // Saturating add of the granted weight into the running window sum.
    always_comb begin
        gnt_weight = granted ? bus.weight[gnt_idx*W +: W] : '0;
        sum_raw    = {1'b0, acc} + {1'b0, gnt_weight};
        clip       = sum_raw[W];
        sum_clip   = clip ? SAT_MAX : sum_raw[W-1:0];
    end

    assign win_end = (win_rem == 8'd0);
    assign win_cnt = WIN_LAST - win_rem;

    // Round-robin pointer advances past each winner; holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (en && granted) begin
            rr_ptr <= rr_next;
        end
    end

    // Window timer: counts down every enabled cycle and reloads at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_rem <= WIN_LAST;
        end else if (en) begin
            if (win_end) begin
                win_rem <= WIN_LAST;
            end else begin
                win_rem <= win_rem - 8'd1;
            end
        end
    end

    // Accumulator and sticky clip flag; both clear when the window closes so
    // a grant in the closing cycle lands in the outgoing sample only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            sat_pend <= 1'b0;
        end else if (en) begin
            if (win_end) begin
                acc      <= '0;
                sat_pend <= 1'b0;
            end else begin
                acc      <= sum_clip;
                sat_pend <= sat_pend | clip;
            end
        end
    end

    // Output sample register: captured at window end, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_syn_q <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (en && win_end) begin
            i_syn_q <= sum_clip;
            sat_q   <= sat_pend | clip;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ack         = ack_c;
    assign bus.i_syn       = i_syn_q;
    assign bus.sat         = sat_q;
    assign bus.i_syn_valid = valid_q;

endmodule

// File: tb/tb_syn_input_arbiter.sv
// Directed and randomized bench for syn_input_arbiter against a cycle-level
// behavioural model of the window/round-robin rules.
module tb_syn_input_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int TSTEP = 16;

    logic              clk;
    logic              rst_n;
    logic              en_d;
    logic [NREQ-1:0]   req_d;
    logic [NREQ*W-1:0] weight_d;
    logic [7:0]        win_cnt;

    syn_input_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    assign bus.req    = req_d;
    assign bus.weight = weight_d;

    syn_input_arbiter #(.NREQ(NREQ), .W(W), .TSTEP(TSTEP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_d),
        .bus     (bus.slave),
        .win_cnt (win_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_rr, m_acc, m_satp, m_win, m_isyn, m_valid, m_sat;
    logic [NREQ-1:0] last_ack_exp;
    logic [NREQ-1:0] last_ack_obs;
    int wcnt [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_rr = 0; m_acc = 0; m_satp = 0; m_win = 0;
        m_isyn = 0; m_valid = 0; m_sat = 0;
    endtask

    // One clock cycle: inputs already applied just after a falling edge.
    task automatic tick();
        bit g;
        int k;
        int s;
        bit c;
        logic [NREQ-1:0] ea;
        #2;
        g = 0; k = 0;
        if (en_d && rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (m_rr + i) % NREQ;
                if (!g && req_d[j]) begin
                    g = 1; k = j;
                end
            end
        end
        ea = '0;
        if (g) ea[k] = 1'b1;
        last_ack_obs = bus.ack;
        last_ack_exp = ea;
        chk("ack", {28'd0, bus.ack}, {28'd0, ea});
        @(posedge clk);
        if (en_d) begin
            s = m_acc;
            if (g) begin
                s = s + int'(weight_d[k*W +: W]);
                m_rr = (k + 1) % NREQ;
            end
            c = (s > 255);
            if (c) s = 255;
            if (m_win == TSTEP - 1) begin
                m_isyn = s; m_sat = (m_satp != 0 || c) ? 1 : 0;
                m_valid = 1; m_acc = 0; m_satp = 0;
            end else begin
                m_acc = s; if (c) m_satp = 1;
                m_valid = 0;
            end
            m_win = (m_win + 1) % TSTEP;
        end else begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("i_syn", {24'd0, bus.i_syn}, 32'(m_isyn));
        chk("i_syn_valid", {31'd0, bus.i_syn_valid}, 32'(m_valid));
        chk("sat", {31'd0, bus.sat}, 32'(m_sat));
        chk("win_cnt", {24'd0, win_cnt}, 32'(m_win));
    endtask

    initial begin
        rst_n = 1'b0; en_d = 1'b0; req_d = '0; weight_d = '0;
        m_reset();
        for (int k = 0; k < NREQ; k++) wcnt[k] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {28'd0, bus.ack}, 32'd0);
        chk("rst_i_syn", {24'd0, bus.i_syn}, 32'd0);
        chk("rst_valid", {31'd0, bus.i_syn_valid}, 32'd0);
        chk("rst_win", {24'd0, win_cnt}, 32'd0);
        rst_n = 1'b1;
        en_d  = 1'b1;

        // 1: idle windows pulse every 16 cycles with a zero sample
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 15 || c == 31) begin
                chk("t1_valid", {31'd0, bus.i_syn_valid}, 32'd1);
                chk("t1_i_syn", {24'd0, bus.i_syn}, 32'd0);
            end
        end

        // 2: all four requesting, rotating grants, sum 40
        while (m_win != 0) tick();
        weight_d = {8'd4, 8'd3, 8'd2, 8'd1};
        req_d    = 4'hF;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t2_ack_seq", {28'd0, last_ack_obs}, 32'd1 << (i % 4));
        end
        req_d = '0;
        chk("t2_i_syn", {24'd0, bus.i_syn}, 32'd40);
        chk("t2_sat", {31'd0, bus.sat}, 32'd0);

        // 3: two grants of 200 saturate, following empty window clears
        weight_d[2*W +: W] = 8'd200;
        req_d = 4'b0100;
        repeat (2) tick();
        req_d = '0;
        repeat (14) tick();
        chk("t3_i_syn", {24'd0, bus.i_syn}, 32'd255);
        chk("t3_sat", {31'd0, bus.sat}, 32'd1);
        repeat (16) tick();
        chk("t3_next_i_syn", {24'd0, bus.i_syn}, 32'd0);
        chk("t3_next_sat", {31'd0, bus.sat}, 32'd0);

        // 4: request landing in the last window cycle
        while (m_win != TSTEP - 1) tick();
        weight_d[1*W +: W] = 8'd5;
        req_d = 4'b0010;
        tick();
        chk("t4_ack", {28'd0, last_ack_obs}, 32'd2);
        req_d = '0;
        chk("t4_valid", {31'd0, bus.i_syn_valid}, 32'd1);
        chk("t4_i_syn", {24'd0, bus.i_syn}, 32'd5);
        repeat (16) tick();
        chk("t4_next_i_syn", {24'd0, bus.i_syn}, 32'd0);

        // 5: enable dropped mid-window freezes everything
        weight_d[3*W +: W] = 8'd7;
        req_d = 4'b1000;
        repeat (5) tick();
        en_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_frozen_win", {24'd0, win_cnt}, 32'd5);
            chk("t5_no_ack", {28'd0, last_ack_obs}, 32'd0);
        end
        en_d = 1'b1;
        repeat (11) tick();
        req_d = '0;
        chk("t5_i_syn", {24'd0, bus.i_syn}, 32'd112);

        // 6: asynchronous reset mid-window discards the partial sum
        weight_d[0 +: W] = 8'd10;
        req_d = 4'b0001;
        repeat (3) tick();
        while (m_win != 9) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_i_syn", {24'd0, bus.i_syn}, 32'd0);
        chk("t6_win", {24'd0, win_cnt}, 32'd0);
        chk("t6_ack", {28'd0, bus.ack}, 32'd0);
        chk("t6_valid", {31'd0, bus.i_syn_valid}, 32'd0);
        chk("t6_sat", {31'd0, bus.sat}, 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        weight_d[2*W +: W] = 8'd9;
        req_d = 4'b0100;
        tick();
        req_d = '0;
        repeat (15) tick();
        chk("t6_post_valid", {31'd0, bus.i_syn_valid}, 32'd1);
        chk("t6_post_i_syn", {24'd0, bus.i_syn}, 32'd9);

        // Randomized requesters obeying the handshake
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int k = 0; k < NREQ; k++) begin
                if (en_d && req_d[k]) begin
                    if (last_ack_exp[k]) begin
                        chk("fair", 32'(wcnt[k] < NREQ), 32'd1);
                        wcnt[k] = 0;
                    end else begin
                        wcnt[k]++;
                    end
                end
                if (!req_d[k]) wcnt[k] = 0;
            end
            for (int k = 0; k < NREQ; k++) begin
                if (last_ack_exp[k]) begin
                    req_d[k] = 1'($urandom % 2);
                    weight_d[k*W +: W] = 8'($urandom);
                    wcnt[k] = 0;
                end else if (!req_d[k]) begin
                    req_d[k] = ($urandom % 3) == 0;
                    weight_d[k*W +: W] = 8'($urandom);
                end
            end
            en_d = ($urandom % 8) != 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
